fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch front end. Consumes the PC value held by the PC register and issues one request at a
//  time to instruction memory. Captures the returned word and presents it to decode via a valid/ready handshake.
//  Pulses pc_advance so the PC register loads its next address only after decode accepts the instruction.
//  Sits between the PC register / next-PC logic, instruction memory, and the decode stage.
// PARAMETERS
//  ADDR_W   `DATA_WIDTH (32)  width of pc_addr, imem_addr and instr_pc
//  INSTR_W  32                width of imem_rdata and instr
//  CNT_W    16                width of fetch_count
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-high reset
//  pc_addr      in   ADDR_W   current PC, driven by the PC register
//  flush        in   1        discard any in-flight or held fetch (branch/jump redirect)
//  imem_req     out  1        request valid toward instruction memory
//  imem_addr    out  ADDR_W   request address; word-aligned
//  imem_ready   in   1        memory accepts request this cycle (imem_req & imem_ready = accept)
//  imem_rvalid  in   1        response data valid; arrives >=1 cycle after accept
//  imem_rdata   in   INSTR_W  response data
//  instr_valid  out  1        instr/instr_pc valid toward decode
//  instr_ready  in   1        decode accepts (instr_valid & instr_ready = handoff)
//  instr        out  INSTR_W  fetched instruction
//  instr_pc     out  ADDR_W   PC that instr was fetched from
//  pc_advance   out  1        1-cycle pulse on handoff; enables PC register update
//  fetch_fault  out  1        misaligned fetch indication (see CONFIGURATION)
//  fetch_count  out  CNT_W    number of handoffs since reset
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE. reset wins over every other input. Reset mid-fetch returns to IDLE.
//  A response arriving while in IDLE is ignored.
//  States: IDLE, REQ, WAIT, HOLD, DROP. At most one outstanding request.
//  IDLE -> REQ unconditionally on the first cycle after reset deasserts.
//  REQ:  imem_req=1, imem_addr={pc_addr[ADDR_W-1:2],2'b00}.
//        accept -> WAIT and latch instr_pc<=pc_addr; otherwise stay in REQ.
//        With flush=1: imem_req forced 0 that cycle, stay in REQ, re-sample pc_addr next cycle.
//  WAIT: imem_rvalid -> capture instr<=imem_rdata, go to HOLD.
//        flush (no rvalid) -> DROP. flush with rvalid the same cycle -> data discarded, go to REQ.
//  HOLD: instr_valid=1. Handoff -> pc_advance=1 this cycle, fetch_count+1, go to REQ.
//        flush has priority over instr_ready: no handoff, no pc_advance, go to REQ.
//  DROP: wait for imem_rvalid, discard data, go to REQ. flush in DROP has no extra effect.
//  instr/instr_pc are stable for the whole time instr_valid=1.
//  Minimum latency: accept to instr_valid = 1 cycle after rvalid. Zero-wait memory gives 1 instr per 3 cycles.
//  fetch_count wraps from 2^CNT_W-1 to 0; no saturation.
//  pc_advance is never asserted outside HOLD.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined:
//    In REQ, pc_addr[1:0]!=0 means no request is issued.
//    Next cycle -> HOLD with instr=32'h00000013 (NOP), instr_pc=pc_addr, fetch_fault=1.
//    Handoff proceeds normally. fetch_fault is cleared on leaving HOLD.
//  FETCH_MISALIGN_TRAP_EN undefined: pc_addr[1:0] ignored (forced to 0), fetch_fault tied to 0.
// STRUCTURE
//  Shared defs.vh gets: `DATA_WIDTH (existing), `INSTR_NOP 32'h00000013, and state encodings
//  `FETCH_IDLE..`FETCH_DROP (3-bit).
//  Single module; no sub-module. The FSM, capture registers and counter are all local.
// TESTING
//  1 reset=1 two cycles then 0, pc_addr=0, imem_ready=1, rvalid 1 cycle after accept, rdata=32'h00500093,
//    instr_ready=1 -> imem_addr=0, instr=00500093, instr_pc=0, pc_advance single pulse, fetch_count=1.
//  2 instr_ready=0 for 4 cycles in HOLD -> instr_valid stays 1, instr stable, no new imem_req, no pc_advance.
//  3 imem_ready=0 for 3 cycles at pc_addr=32'h10 -> imem_req held with imem_addr=10.
//    Accept on 4th cycle; exactly one request.
//  4 flush in WAIT, late rvalid with rdata=DEADBEEF -> DEADBEEF never shown on instr.
//    Next request uses new pc_addr=32'h40.
//  5 flush and instr_ready both 1 in HOLD -> no pc_advance, fetch_count unchanged.
//    reset asserted in WAIT -> next cycle all outputs 0.
//  6 pc_addr=32'h0000_0006: with FETCH_MISALIGN_TRAP_EN -> no imem_req, instr=00000013, fetch_fault=1.
//    Without it -> imem_addr=32'h4, fetch_fault=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// the NOP used for trapped fetches, and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int INSTR_WIDTH = 32;
    localparam int COUNT_WIDTH = 16;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH_IDLE = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        FETCH_HOLD = 3'd3,
        FETCH_DROP = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Issues one word-aligned request at a time to
// instruction memory, holds the returned word for decode under a valid/ready
// handshake, and pulses o_pc_advance when decode takes the instruction.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned PC produces a
// NOP with o_fetch_fault instead of a memory request).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = DATA_WIDTH,
    parameter int INSTR_W = INSTR_WIDTH,
    parameter int CNT_W   = COUNT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [ADDR_W-1:0]  i_pc_addr,
    input  logic               i_flush,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ready,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_pc,
    output logic               o_pc_advance,
    output logic               o_fetch_fault,
    output logic [CNT_W-1:0]   o_fetch_count
);

    fetch_state_t       r_state;
    fetch_state_t       w_next_state;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic [CNT_W-1:0]   r_fetch_count;
    logic               r_fault;

    logic [ADDR_W-1:0]  w_aligned_addr;
    logic               w_misaligned;
    logic               w_imem_req;
    logic               w_accept;
    logic               w_capture;
    logic               w_trap;
    logic               w_handoff;
    logic               w_leave_hold;

    assign w_aligned_addr = {i_pc_addr[ADDR_W-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misaligned = |i_pc_addr[1:0];
`else
    assign w_misaligned = 1'b0;
`endif

    // State register; reset always returns the fetch engine to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; flush outranks both memory and decode.
    always_comb begin
        w_next_state = r_state;
        w_imem_req   = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_trap       = 1'b0;
        w_handoff    = 1'b0;
        unique case (r_state)
            FETCH_IDLE: begin
                w_next_state = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (!i_flush) begin
                    if (w_misaligned) begin
                        w_trap       = 1'b1;
                        w_next_state = FETCH_HOLD;
                    end else begin
                        w_imem_req = 1'b1;
                        if (i_imem_ready) begin
                            w_accept     = 1'b1;
                            w_next_state = FETCH_WAIT;
                        end
                    end
                end
            end
            FETCH_WAIT: begin
                if (i_flush) begin
                    w_next_state = i_imem_rvalid ? FETCH_REQ : FETCH_DROP;
                end else if (i_imem_rvalid) begin
                    w_capture    = 1'b1;
                    w_next_state = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (i_flush) begin
                    w_next_state = FETCH_REQ;
                end else if (i_instr_ready) begin
                    w_handoff    = 1'b1;
                    w_next_state = FETCH_REQ;
                end
            end
            FETCH_DROP: begin
                if (i_imem_rvalid) begin
                    w_next_state = FETCH_REQ;
                end
            end
            default: begin
                w_next_state = FETCH_IDLE;
            end
        endcase
    end

    assign w_leave_hold = (r_state == FETCH_HOLD) && (w_next_state != FETCH_HOLD);

    // Capture registers and handoff counter; contents only change outside HOLD
    // so decode always sees a stable instruction while it is valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_fetch_count <= '0;
            r_fault       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_instr_pc <= w_aligned_addr;
            end
            if (w_capture) begin
                r_instr <= i_imem_rdata;
            end
            if (w_trap) begin
                r_instr    <= INSTR_W'(INSTR_NOP);
                r_instr_pc <= i_pc_addr;
                r_fault    <= 1'b1;
            end else if (w_leave_hold) begin
                r_fault <= 1'b0;
            end
            if (w_handoff) begin
                r_fetch_count <= r_fetch_count + 1'b1;
            end
        end
    end

    assign o_imem_req    = w_imem_req & ~i_reset;
    assign o_imem_addr   = o_imem_req ? w_aligned_addr : '0;
    assign o_instr_valid = (r_state == FETCH_HOLD) & ~i_reset;
    assign o_pc_advance  = w_handoff & ~i_reset;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_fetch_fault = r_fault;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Inputs change 1 time unit after
// the rising edge; outputs are checked 3 units later, mid-cycle.
// Expectations for the misaligned-PC case follow FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcAddr;
    logic        flush;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        pcAdvance;
    logic        fetchFault;
    logic [15:0] fetchCount;

    int checkCount = 0;
    int errorCount = 0;
    int advanceSeen;

    fetch_unit dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_pc_addr     (pcAddr),
        .i_flush       (flush),
        .o_imem_req    (imemReq),
        .o_imem_addr   (imemAddr),
        .i_imem_ready  (imemReady),
        .i_imem_rvalid (imemRvalid),
        .i_imem_rdata  (imemRdata),
        .o_instr_valid (instrValid),
        .i_instr_ready (instrReady),
        .o_instr       (instr),
        .o_instr_pc    (instrPc),
        .o_pc_advance  (pcAdvance),
        .o_fetch_fault (fetchFault),
        .o_fetch_count (fetchCount)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic fl, input logic [31:0] pc,
                                 input logic rdy, input logic rv, input logic [31:0] rd,
                                 input logic iRdy);
        reset      = rst;
        flush      = fl;
        pcAddr     = pc;
        imemReady  = rdy;
        imemRvalid = rv;
        imemRdata  = rd;
        instrReady = iRdy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        // Test 1: reset, then a single zero-wait fetch at PC 0.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        nextCycle();
        nextCycle();
        settle();
        checkOutput("rst_req", imemReq, 0);
        checkOutput("rst_addr", imemAddr, 0);
        checkOutput("rst_valid", instrValid, 0);
        checkOutput("rst_instr", instr, 0);
        checkOutput("rst_count", fetchCount, 0);
        checkOutput("rst_fault", fetchFault, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("idle_no_req", imemReq, 0);
        nextCycle();
        settle();
        checkOutput("t1_req", imemReq, 1);
        checkOutput("t1_addr", imemAddr, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0050_0093, 1'b1);
        settle();
        checkOutput("t1_wait_no_req", imemReq, 0);
        checkOutput("t1_wait_valid", instrValid, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t1_valid", instrValid, 1);
        checkOutput("t1_instr", instr, 32'h0050_0093);
        checkOutput("t1_instr_pc", instrPc, 32'h0);
        checkOutput("t1_advance", pcAdvance, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h4, 1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        checkOutput("t1_advance_pulse", pcAdvance, 0);
        checkOutput("t1_count", fetchCount, 1);
        checkOutput("t2_req_addr", imemAddr, 32'h4);

        // Test 2: decode stalls for four cycles in HOLD.
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h4, 1'b1, 1'b1, 32'h0010_0113, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h4, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) nextCycle();
            settle();
            checkOutput($sformatf("t2_valid_%0d", i), instrValid, 1);
            checkOutput($sformatf("t2_instr_%0d", i), instr, 32'h0010_0113);
            checkOutput($sformatf("t2_no_req_%0d", i), imemReq, 0);
            checkOutput($sformatf("t2_no_adv_%0d", i), pcAdvance, 0);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h4, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t2_advance", pcAdvance, 1);
        checkOutput("t2_instr_pc", instrPc, 32'h4);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t2_count", fetchCount, 2);

        // Test 3: memory back-pressure for three cycles at PC 0x10.
        for (int i = 0; i < 3; i++) begin
            if (i != 0) nextCycle();
            settle();
            checkOutput($sformatf("t3_req_%0d", i), imemReq, 1);
            checkOutput($sformatf("t3_addr_%0d", i), imemAddr, 32'h10);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t3_accept_req", imemReq, 1);
        nextCycle();
        settle();
        checkOutput("t3_single_req_a", imemReq, 0);
        nextCycle();
        settle();
        checkOutput("t3_single_req_b", imemReq, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h0020_8193, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t3_instr", instr, 32'h0020_8193);
        checkOutput("t3_instr_pc", instrPc, 32'h10);
        checkOutput("t3_advance", pcAdvance, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t3_count", fetchCount, 3);

        // Test 4: flush in WAIT, late DEADBEEF response is dropped.
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t4_wait_no_req", imemReq, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t4_drop_valid", instrValid, 0);
        checkOutput("t4_drop_no_req", imemReq, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
        settle();
        checkOutput("t4_drop_rvalid_valid", instrValid, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t4_flush_req", imemReq, 0);
        checkOutput("t4_instr_kept", instr, 32'h0020_8193);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t4_req", imemReq, 1);
        checkOutput("t4_addr", imemAddr, 32'h40);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 32'h0030_8213, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t4_instr", instr, 32'h0030_8213);
        checkOutput("t4_instr_pc", instrPc, 32'h40);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h44, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t4_count", fetchCount, 4);

        // Test 5: flush beats instr_ready in HOLD, then reset mid-fetch.
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h44, 1'b1, 1'b1, 32'h0040_8293, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t5_hold_valid", instrValid, 1);
        checkOutput("t5_flush_no_adv", pcAdvance, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h48, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t5_count_kept", fetchCount, 4);
        checkOutput("t5_req", imemReq, 1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h48, 1'b1, 1'b0, 32'h0, 1'b1);
        nextCycle();
        settle();
        checkOutput("t5_rst_req", imemReq, 0);
        checkOutput("t5_rst_addr", imemAddr, 0);
        checkOutput("t5_rst_valid", instrValid, 0);
        checkOutput("t5_rst_instr", instr, 0);
        checkOutput("t5_rst_instr_pc", instrPc, 0);
        checkOutput("t5_rst_adv", pcAdvance, 0);
        checkOutput("t5_rst_count", fetchCount, 0);
        checkOutput("t5_rst_fault", fetchFault, 0);

        // Test 6: misaligned PC 0x6.
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h6, 1'b1, 1'b0, 32'h0, 1'b1);
        nextCycle();
        settle();
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("t6_no_req", imemReq, 0);
        nextCycle();
        settle();
        checkOutput("t6_valid", instrValid, 1);
        checkOutput("t6_nop", instr, 32'h0000_0013);
        checkOutput("t6_instr_pc", instrPc, 32'h6);
        checkOutput("t6_fault", fetchFault, 1);
        checkOutput("t6_advance", pcAdvance, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h8, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t6_fault_clear", fetchFault, 0);
`else
        checkOutput("t6_req", imemReq, 1);
        checkOutput("t6_addr", imemAddr, 32'h4);
        checkOutput("t6_fault", fetchFault, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h6, 1'b1, 1'b1, 32'h0050_8313, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h6, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        checkOutput("t6_instr", instr, 32'h0050_8313);
        checkOutput("t6_instr_pc", instrPc, 32'h4);
        checkOutput("t6_hold_fault", fetchFault, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h8, 1'b1, 1'b0, 32'h0, 1'b1);
        settle();
`endif
        checkOutput("t6_count", fetchCount, 1);

        // Zero-wait memory streams one instruction every three cycles.
        applyStimulus(1'b0, 1'b0, 32'h8, 1'b1, 1'b1, 32'h0060_8393, 1'b1);
        advanceSeen = 0;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) nextCycle();
            settle();
            if (pcAdvance === 1'b1) advanceSeen++;
        end
        checkOutput("tp_advances", advanceSeen, 3);
        nextCycle();
        settle();
        checkOutput("tp_count", fetchCount, 4);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
